// File: rtl/capture_trig_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : capture_trig_ctrl
//  Description : Write-side controller for the dual-port sample RAM (port A).
//                Streams accepted ADC samples into the RAM as a ring buffer,
//                holds a programmable pre-trigger depth, detects a level/edge
//                or software trigger, fills the post-trigger remainder and
//                reports the oldest-sample address for the port-B reader.
//  Ports       :
//    clk           single clock (also drives RAM port A clock)
//    rst           asynchronous reset, active-high
//    arm           1-cycle pulse, starts or restarts a capture
//    sample_in     unsigned ADC sample
//    sample_valid  sample_in is offered this cycle
//    trig_level    unsigned trigger threshold
//    trig_edge     0 = rising edge, 1 = falling edge
//    force_trig    1-cycle pulse, software trigger (ARMED only)
//    pretrig_len   pre-trigger sample count P, sampled on arm
//    ram_addr      RAM port A address
//    ram_wr_data   RAM port A write data
//    ram_wr_en     RAM port A write enable
//    busy          capture in progress (PREFILL/ARMED/POST)
//    trig_seen     trigger taken for the current capture
//    done          capture complete, RAM contents stable
//    start_addr    address of the oldest sample, valid while done=1
//  Revision    : 1.0  initial release
// ============================================================================
module capture_trig_ctrl #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic                  trig_edge,
  input  logic                  force_trig,
  input  logic [ADDR_WIDTH-1:0] pretrig_len,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_wr_en,
  output logic                  busy,
  output logic                  trig_seen,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] start_addr
);

  // Ring depth expressed one bit wider so DEPTH itself is representable.
  localparam logic [ADDR_WIDTH:0] c_depth    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] c_cnt_one  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREFILL = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wp;          // next RAM write address
  logic [ADDR_WIDTH-1:0] r_p;           // pre-trigger depth latched at arm
  logic [ADDR_WIDTH:0]   r_cnt;         // samples written in current phase
  logic [DATA_WIDTH-1:0] r_prev;        // last accepted sample
  logic                  r_prev_valid;
  logic                  r_force_pend;
  logic [ADDR_WIDTH-1:0] r_trig_addr;

  logic                  w_capturing;
  logic                  w_accept;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_edge_hit;
  logic                  w_trig;
  logic [ADDR_WIDTH:0]   w_cnt_inc;
  logic [ADDR_WIDTH:0]   w_post_len;

  assign w_capturing = (r_state == S_PREFILL) || (r_state == S_ARMED) ||
                       (r_state == S_POST);

  // An arm in the same cycle wins: the offered sample is dropped.
  assign w_accept    = sample_valid && !arm && w_capturing;

  // Edge detection needs a previous sample from this capture.
  assign w_rise      = r_prev_valid && (r_prev < trig_level) &&
                       (sample_in >= trig_level);
  assign w_fall      = r_prev_valid && (r_prev > trig_level) &&
                       (sample_in <= trig_level);
  assign w_edge_hit  = trig_edge ? w_fall : w_rise;

  // A software trigger arriving with a valid sample triggers on that sample.
  assign w_trig      = (r_state == S_ARMED) && w_accept &&
                       (w_edge_hit || r_force_pend || force_trig);

  assign w_cnt_inc   = r_cnt + c_cnt_one;

  // Post-trigger sample count, trigger sample included. The pretrig_len port
  // width already bounds P to DEPTH-1, so at least one post sample remains.
  assign w_post_len  = c_depth - {1'b0, r_p};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wp         <= '0;
      r_p          <= '0;
      r_cnt        <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_force_pend <= 1'b0;
      r_trig_addr  <= '0;
      ram_addr     <= '0;
      ram_wr_data  <= '0;
      ram_wr_en    <= 1'b0;
      busy         <= 1'b0;
      trig_seen    <= 1'b0;
      done         <= 1'b0;
      start_addr   <= '0;
    end else begin
      ram_wr_en <= 1'b0;
      // Status flags follow the state one cycle later, so done rises one
      // cycle after the final write has been presented to the RAM.
      busy      <= w_capturing;
      done      <= (r_state == S_DONE);

      if (arm) begin
        r_wp         <= '0;
        r_p          <= pretrig_len;
        r_cnt        <= '0;
        r_prev_valid <= 1'b0;
        r_force_pend <= 1'b0;
        trig_seen    <= 1'b0;
        done         <= 1'b0;
        busy         <= 1'b1;
        r_state      <= (pretrig_len == '0) ? S_ARMED : S_PREFILL;
      end else begin
        if (w_accept) begin
          ram_addr     <= r_wp;
          ram_wr_data  <= sample_in;
          ram_wr_en    <= 1'b1;
          r_wp         <= r_wp + 1'b1;
          r_prev       <= sample_in;
          r_prev_valid <= 1'b1;
        end

        case (r_state)
          S_PREFILL: begin
            if (w_accept) begin
              if (w_cnt_inc == {1'b0, r_p}) begin
                r_state <= S_ARMED;
                r_cnt   <= '0;
              end else begin
                r_cnt   <= w_cnt_inc;
              end
            end
          end

          S_ARMED: begin
            if (w_trig) begin
              r_trig_addr  <= r_wp;
              trig_seen    <= 1'b1;
              r_force_pend <= 1'b0;
              r_cnt        <= c_cnt_one;
              // With maximum pre-trigger depth the trigger is the last write.
              r_state      <= (w_post_len == c_cnt_one) ? S_DONE : S_POST;
            end else if (force_trig) begin
              r_force_pend <= 1'b1;
            end
          end

          S_POST: begin
            if (w_accept) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == w_post_len) begin
                r_state <= S_DONE;
              end
            end
          end

          S_DONE: begin
            // Oldest sample sits P entries before the trigger, mod DEPTH.
            start_addr <= r_trig_addr - r_p;
          end

          default: begin
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_capture_trig_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : tb_capture_trig_ctrl
//  Description : Scoreboard bench for capture_trig_ctrl. Directed stimulus
//                pushes expected RAM writes into a queue; a monitor pops and
//                compares on every ram_wr_en and keeps a shadow RAM.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_capture_trig_ctrl;

  localparam int AW    = 13;
  localparam int DW    = 11;
  localparam int DEPTH = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic [DW-1:0] trig_level;
  logic          trig_edge;
  logic          force_trig;
  logic [AW-1:0] pretrig_len;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_wr_en;
  logic          busy;
  logic          trig_seen;
  logic          done;
  logic [AW-1:0] start_addr;

  capture_trig_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .trig_level   (trig_level),
    .trig_edge    (trig_edge),
    .force_trig   (force_trig),
    .pretrig_len  (pretrig_len),
    .ram_addr     (ram_addr),
    .ram_wr_data  (ram_wr_data),
    .ram_wr_en    (ram_wr_en),
    .busy         (busy),
    .trig_seen    (trig_seen),
    .done         (done),
    .start_addr   (start_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  int            checks   = 0;
  int            failures = 0;
  wr_t           exp_q[$];
  logic [DW-1:0] hist[$];
  logic [DW-1:0] shadow [0:DEPTH-1];
  logic [AW-1:0] tb_wp;
  logic [DW-1:0] trig_data;
  logic          pat_chk = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every presented write must match the oldest expected write.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (ram_wr_en === 1'b1) begin
        shadow[ram_addr] = ram_wr_data;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr=%0d data=%0d expected no write at %0t",
                   ram_addr, ram_wr_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(ram_addr), 32'(e.addr));
          chk("wr_data", 32'(ram_wr_data), 32'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic f);
    sample_in    = d;
    sample_valid = 1'b1;
    force_trig   = f;
    exp_q.push_back('{addr: tb_wp, data: d});
    hist.push_back(d);
    tb_wp++;
    tick();
    sample_valid = 1'b0;
    force_trig   = 1'b0;
    if (pat_chk) chk("wr_en_after_valid", 32'(ram_wr_en), 1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      if (pat_chk) chk("wr_en_after_idle", 32'(ram_wr_en), 0);
    end
  endtask

  task automatic do_arm(input logic [AW-1:0] p, input logic with_sample);
    pretrig_len  = p;
    arm          = 1'b1;
    sample_valid = with_sample;
    sample_in    = 11'h7AA;
    tick();
    arm          = 1'b0;
    sample_valid = 1'b0;
    tb_wp        = '0;
    hist.delete();
    chk("arm_busy", 32'(busy), 1);
    chk("arm_done", 32'(done), 0);
    chk("arm_trig_seen", 32'(trig_seen), 0);
  endtask

  // Called right after the final write of a capture has been issued.
  task automatic finish_capture(input logic [AW-1:0] p, input logic [AW-1:0] exp_start);
    logic [AW-1:0] a;
    chk("busy_before_done", 32'(busy), 1);
    chk("done_early", 32'(done), 0);
    tick();
    chk("done", 32'(done), 1);
    chk("busy_after_done", 32'(busy), 0);
    chk("start_addr", 32'(start_addr), 32'(exp_start));
    chk("trig_seen_hold", 32'(trig_seen), 1);
    chk("ring_oldest", 32'(shadow[exp_start]), 32'(hist[hist.size()-DEPTH]));
    a = exp_start + p;
    chk("ring_trigger", 32'(shadow[a]), 32'(trig_data));
    a = exp_start - 1'b1;
    chk("ring_newest", 32'(shadow[a]), 32'(hist[hist.size()-1]));
    chk("sb_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin : stimulus
    rst = 1'b1; arm = 1'b0; sample_in = '0; sample_valid = 1'b0;
    trig_level = '0; trig_edge = 1'b0; force_trig = 1'b0; pretrig_len = '0;
    tb_wp = '0; trig_data = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wr_en", 32'(ram_wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_trig_seen", 32'(trig_seen), 0);
    chk("rst_start_addr", 32'(start_addr), 0);

    // P=0, rising through 100 on a ramp: trigger at addr 100.
    trig_edge = 1'b0; trig_level = 11'd100;
    do_arm(13'd0, 1'b0);
    for (int i = 0; i < 100; i++) send(11'(i), 1'b0);
    chk("t2_no_trig_yet", 32'(trig_seen), 0);
    trig_data = 11'd100;
    send(11'd100, 1'b0);
    chk("t2_trig_seen", 32'(trig_seen), 1);
    for (int i = 101; i <= 8291; i++) send(11'(i), 1'b0);
    finish_capture(13'd0, 13'd100);

    // Asynchronous reset in the middle of POST.
    do_arm(13'd0, 1'b0);
    trig_data = 11'd5;
    send(11'd5, 1'b1);
    send(11'd6, 1'b0); send(11'd7, 1'b0); send(11'd8, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_ram_addr", 32'(ram_addr), 0);
    chk("arst_ram_wr_data", 32'(ram_wr_data), 0);
    chk("arst_ram_wr_en", 32'(ram_wr_en), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_trig_seen", 32'(trig_seen), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_start_addr", 32'(start_addr), 0);
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    sample_valid = 1'b1; sample_in = 11'h123;
    tick(); tick(); tick(); tick();
    sample_valid = 1'b0;
    tick();
    chk("idle_no_busy", 32'(busy), 0);
    chk("idle_no_wr_en", 32'(ram_wr_en), 0);

    // P=1000, trigger at wp=200 -> ring wraps, start at 7392.
    trig_edge = 1'b0; trig_level = 11'h400;
    do_arm(13'd1000, 1'b0);
    for (int i = 0; i < 1000; i++) send(11'(i & 'h3FF), 1'b0);
    for (int i = 0; i < 7392; i++) send(11'((i * 7) & 'h3FF), 1'b0);
    chk("t3_no_trig_yet", 32'(trig_seen), 0);
    chk("t3_wp_at_trig", 32'(tb_wp), 200);
    trig_data = 11'h5A5;
    send(trig_data, 1'b0);
    chk("t3_trig_seen", 32'(trig_seen), 1);
    for (int i = 0; i < 7191; i++) send(11'(11'h600 | (i & 'hFF)), 1'b0);
    finish_capture(13'd1000, 13'd7392);

    // Constant 0x3FF never edge-triggers; force_trig with no valid sample
    // makes the next accepted sample the trigger. Force in PREFILL ignored.
    trig_edge = 1'b0; trig_level = 11'h100;
    do_arm(13'd50, 1'b0);
    for (int i = 0; i < 55; i++) send(11'h3FF, (i == 10));
    chk("t4_prefill_force_ignored", 32'(trig_seen), 0);
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    tick(); tick();
    chk("t4_pending_not_trig", 32'(trig_seen), 0);
    trig_data = 11'h3FF;
    send(11'h3FF, 1'b0);
    chk("t4_trig_seen", 32'(trig_seen), 1);
    for (int i = 0; i < 8141; i++) send(11'h3FF, 1'b0);
    finish_capture(13'd50, 13'd5);

    // Falling edge at 0x400, sample_valid every other cycle.
    trig_edge = 1'b1; trig_level = 11'h400;
    pat_chk = 1'b1;
    do_arm(13'd16, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send((i < 8) ? 11'h300 : 11'h500, 1'b0);
      idle(1);
    end
    send(11'h500, 1'b0); idle(1);
    send(11'h500, 1'b0); idle(1);
    send(11'h600, 1'b0); idle(1);
    send(11'h500, 1'b0); idle(1);
    chk("t5_no_trig_yet", 32'(trig_seen), 0);
    trig_data = 11'h400;
    send(11'h400, 1'b0);
    chk("t5_trig_seen", 32'(trig_seen), 1);
    pat_chk = 1'b0;
    for (int i = 0; i < 8175; i++) begin
      idle(1);
      send(11'(i & 'h7F), 1'b0);
    end
    finish_capture(13'd16, 13'd4);

    // Re-arm in the middle of POST, with a same-cycle sample that is dropped;
    // then maximum pre-trigger depth leaves only the trigger as post sample.
    trig_edge = 1'b0; trig_level = 11'h7FF;
    do_arm(13'd10, 1'b0);
    for (int i = 0; i < 10; i++) send(11'd1, 1'b0);
    send(11'd2, 1'b1);
    for (int i = 0; i < 5; i++) send(11'd3, 1'b0);
    chk("t6_in_post_busy", 32'(busy), 1);
    chk("t6_in_post_trig", 32'(trig_seen), 1);
    do_arm(13'd8191, 1'b1);
    for (int i = 0; i < 8191; i++) send(11'(i & 'h3FF), 1'b0);
    chk("t6_no_trig_yet", 32'(trig_seen), 0);
    trig_data = 11'h555;
    send(11'h555, 1'b1);
    chk("t6_trig_seen", 32'(trig_seen), 1);
    finish_capture(13'd8191, 13'd0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
